// File: rtl/bin_search_pkg.sv
// Shared types for the binary-search engine: FSM state encoding and the legal
// range of the RAM read latency parameter.
package bin_search_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMPARE,
      S_DONE
   } search_state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/bin_search_dp.sv
// Search datapath: low/high window, probe address, target latch, probe counter and result.
// Registers update only on the load/issue/compare strobes from the controlling FSM.
module bin_search_dp
   import bin_search_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              issue,
   input  logic              cmp,
   input  logic [DATA_W-1:0] target,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mid,
   output logic              cmp_end,
   output logic              found,
   output logic [ADDR_W-1:0] index,
   output logic [ADDR_W:0]   probes
);

   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W:0]   PROBE_ONE = 1;

   logic [ADDR_W-1:0] low_q, low_d, high_q, high_d, index_q, index_d;
   logic [DATA_W-1:0] tgt_q, tgt_d;
   logic [ADDR_W:0]   probes_q, probes_d;
   logic              found_q, found_d;
   logic [ADDR_W:0]   sum;
   logic              eq, lt;

   // Sum is one bit wider so low+high cannot overflow before the halving.
   assign sum = {1'b0, low_q} + {1'b0, high_q};
   assign mid = sum[ADDR_W:1];

   assign eq      = (rd_data == tgt_q);
   assign lt      = (tgt_q < rd_data);
   assign cmp_end = eq | (lt ? (mid == low_q) : (mid == high_q));

   always_comb begin
      low_d    = low_q;
      high_d   = high_q;
      tgt_d    = tgt_q;
      probes_d = probes_q;
      found_d  = found_q;
      index_d  = index_q;
      if (load) begin
         tgt_d    = target;
         low_d    = '0;
         high_d   = '1;
         probes_d = '0;
         found_d  = 1'b0;
         index_d  = '0;
      end else begin
         if (issue) probes_d = probes_q + PROBE_ONE;
         // Window edges move only when the probe is not already at that edge.
         if (cmp) begin
            if (eq) begin
               found_d = 1'b1;
               index_d = mid;
            end else if (lt) begin
               if (mid != low_q) high_d = mid - ADDR_ONE;
            end else begin
               if (mid != high_q) low_d = mid + ADDR_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         low_q    <= '0;
         high_q   <= '0;
         tgt_q    <= '0;
         probes_q <= '0;
         found_q  <= 1'b0;
         index_q  <= '0;
      end else begin
         low_q    <= low_d;
         high_q   <= high_d;
         tgt_q    <= tgt_d;
         probes_q <= probes_d;
         found_q  <= found_d;
         index_q  <= index_d;
      end
   end

   assign found  = found_q;
   assign index  = index_q;
   assign probes = probes_q;

endmodule

// File: rtl/bin_search_engine.sv
// Binary search of a sorted sync RAM; each probe costs RD_LAT+1 cycles, result held in
// DONE until start drops, start/target ignored while busy.
module bin_search_engine
   import bin_search_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] target,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] index,
   output logic [ADDR_W:0]   probes
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("bin_search_engine: RD_LAT must be in 1..4");
   end

   localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

   search_state_t     state_q, state_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic              load, issue, cmp, cmp_end;
   logic [ADDR_W-1:0] mid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_ISSUE;
         S_ISSUE: begin
            wait_cnt_d = WAIT_INIT;
            state_d    = (RD_LAT > 1) ? S_WAIT : S_COMPARE;
         end
         S_WAIT: begin
            if (wait_cnt_q == 2'd0) state_d = S_COMPARE;
            else                    wait_cnt_d = wait_cnt_q - 2'd1;
         end
         S_COMPARE: state_d = cmp_end ? S_DONE : S_ISSUE;
         S_DONE:    if (!start) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      load    = 1'b0;
      issue   = 1'b0;
      cmp     = 1'b0;
      rd_addr = '0;
      case (state_q)
         S_IDLE:    load = start;
         S_ISSUE: begin
            busy    = 1'b1;
            issue   = 1'b1;
            rd_addr = mid;
         end
         S_WAIT: begin
            busy    = 1'b1;
            rd_addr = mid;
         end
         S_COMPARE: begin
            busy    = 1'b1;
            cmp     = 1'b1;
            rd_addr = mid;
         end
         S_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   bin_search_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dp (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .issue   (issue),
      .cmp     (cmp),
      .target  (target),
      .rd_data (rd_data),
      .mid     (mid),
      .cmp_end (cmp_end),
      .found   (found),
      .index   (index),
      .probes  (probes)
   );

endmodule
